// File: rtl/clk_ratio_meter.sv
// Measures a divided clock (clk_in) against clk: period, optional high time, lock and loss-of-clock.
// High-time measurement is built only when CLK_RATIO_DUTY_EN is defined; otherwise high_out is 0.
module clk_ratio_meter #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int LOCK_CNT    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
);
    // state | meaning
    // SEEK  | after reset or timeout, waiting for a rising edge to arm the counters
    // RUN   | counting between rising edges, reporting each completed period
    typedef enum logic {SEEK = 1'b0, RUN = 1'b1} state_t;

    // Last count before the period would become unmeasurable.
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_CNT);

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl_d_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       period_q;
    logic [3:0]             match_q;
    logic                   meas_valid_q;
    logic                   locked_q;
    logic                   timeout_q;

    logic                   lvl;
    logic                   rise_p;
    logic [CNT_W-1:0]       cnt_d;
    logic [3:0]             match_d;
    logic                   locked_d;

    assign lvl    = sync_q[SYNC_STAGES-1];
    assign rise_p = lvl & ~lvl_d_q;

    always_comb begin
        cnt_d = cnt_q + CNT_ONE;
        if ((match_q != 4'd0) && (cnt_d == period_q))
            match_d = (match_q >= LOCK_MAX) ? LOCK_MAX : match_q + 4'd1;
        else
            match_d = 4'd1;
        locked_d = (match_d >= LOCK_MAX);
    end

`ifdef CLK_RATIO_DUTY_EN
    logic [CNT_W-1:0] hi_cnt_q;
    logic [CNT_W-1:0] hi_cnt_d;
    logic [CNT_W-1:0] high_q;

    assign hi_cnt_d = hi_cnt_q + {{(CNT_W-1){1'b0}}, lvl};
    assign high_out = high_q;
`else
    assign high_out = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SEEK;
            sync_q       <= '0;
            lvl_d_q      <= 1'b0;
            cnt_q        <= '0;
            period_q     <= '0;
            match_q      <= 4'd0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
`ifdef CLK_RATIO_DUTY_EN
            hi_cnt_q     <= '0;
            high_q       <= '0;
`endif
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], clk_in};
            lvl_d_q      <= lvl;
            meas_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                SEEK: begin
                    if (rise_p) begin
                        cnt_q    <= '0;
`ifdef CLK_RATIO_DUTY_EN
                        hi_cnt_q <= CNT_ONE;
`endif
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    // A rise on the last count still yields a valid maximum period.
                    if (rise_p) begin
                        period_q     <= cnt_d;
                        meas_valid_q <= 1'b1;
                        match_q      <= match_d;
                        locked_q     <= locked_d;
                        cnt_q        <= '0;
`ifdef CLK_RATIO_DUTY_EN
                        high_q       <= hi_cnt_q;
                        hi_cnt_q     <= CNT_ONE;
`endif
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                        match_q   <= 4'd0;
                        state_q   <= SEEK;
                    end else begin
                        cnt_q    <= cnt_d;
`ifdef CLK_RATIO_DUTY_EN
                        hi_cnt_q <= hi_cnt_d;
`endif
                    end
                end
                default: state_q <= SEEK;
            endcase
        end
    end

    assign period_out = period_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule
